// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: PC realignment, slot validity tracking and registered ID/EX bank.
module decode #(
  parameter int INSTR_WIDTH    = 32,
  parameter int PC_WIDTH       = 12,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [INSTR_WIDTH-1:0]    instr_in,
  input  logic [PC_WIDTH-1:0]       pc_in,
  output logic                      valid_out,
  output logic [PC_WIDTH-1:0]       pc_out,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     imm,
  output logic [3:0]                alu_op,
  output logic                      src_b_imm,
  output logic                      reg_we,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [2:0]                mem_funct3,
  output logic                      branch_op,
  output logic                      jump_op,
  output logic                      illegal_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic                  in_valid_q;
  logic [PC_WIDTH-1:0]   pc_dly_q;
  logic                  valid_q;
  logic [PC_WIDTH-1:0]   pc_out_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic [2:0]            funct3_q;
  logic                  src_b_imm_q, src_b_imm_d;
  logic                  reg_we_q, reg_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic                  branch_q, branch_d;
  logic                  jump_q, jump_d;
  logic                  illegal_q, illegal_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic we, re, mwe, br, jmp, ill;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  assign imm_i = {{(DATA_WIDTH-12){instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){instr_in[31]}}, instr_in[31], instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-32){instr_in[31]}}, instr_in[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};

  always_comb begin
    we = 1'b0; re = 1'b0; mwe = 1'b0; br = 1'b0; jmp = 1'b0; ill = 1'b0;
    src_b_imm_d = 1'b0;
    alu_op_d    = 4'b0000;
    imm_d       = '0;
    case (opcode)
      OP_R: begin
        we       = 1'b1;
        alu_op_d = {instr_in[30], funct3};
        ill      = !((funct7 == F7_ZERO) ||
                     (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        we = 1'b1; src_b_imm_d = 1'b1; imm_d = imm_i;
        alu_op_d = {(funct3 == 3'b101) ? instr_in[30] : 1'b0, funct3};
        if (funct3 == 3'b001) ill = (funct7 != F7_ZERO);
        if (funct3 == 3'b101) ill = !(funct7 == F7_ZERO || funct7 == F7_ALT);
      end
      OP_LOAD: begin
        re = 1'b1; we = 1'b1; src_b_imm_d = 1'b1; imm_d = imm_i;
        ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        mwe = 1'b1; src_b_imm_d = 1'b1; imm_d = imm_s;
        ill = funct3[2] || (funct3 == 3'b011);
      end
      OP_BRANCH: begin
        br = 1'b1; imm_d = imm_b; alu_op_d = {1'b0, funct3};
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        jmp = 1'b1; we = 1'b1; imm_d = imm_j;
      end
      OP_JALR: begin
        jmp = 1'b1; we = 1'b1; src_b_imm_d = 1'b1; imm_d = imm_i;
        ill = (funct3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        we = 1'b1; src_b_imm_d = 1'b1; imm_d = imm_u;
      end
      OP_MISC: ;
      OP_SYSTEM: ill = !(instr_in == 32'h0000_0073 || instr_in == 32'h0010_0073);
      default:   ill = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) ill = 1'b1;

    // Squashed slots and illegal words must never cause side effects downstream.
    illegal_d = in_valid_q & ill;
    reg_we_d  = in_valid_q & ~ill & we & (instr_in[11:7] != 5'd0);
    mem_re_d  = in_valid_q & ~ill & re;
    mem_we_d  = in_valid_q & ~ill & mwe;
    branch_d  = in_valid_q & ~ill & br;
    jump_d    = in_valid_q & ~ill & jmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0; pc_dly_q <= '0; valid_q <= 1'b0; pc_out_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; imm_q <= '0; alu_op_q <= '0;
      funct3_q <= '0; src_b_imm_q <= 1'b0; reg_we_q <= 1'b0; mem_re_q <= 1'b0;
      mem_we_q <= 1'b0; branch_q <= 1'b0; jump_q <= 1'b0; illegal_q <= 1'b0;
    end else if (flush) begin
      in_valid_q <= 1'b0; pc_dly_q <= pc_in; valid_q <= 1'b0;
      reg_we_q <= 1'b0; mem_re_q <= 1'b0; mem_we_q <= 1'b0;
      branch_q <= 1'b0; jump_q <= 1'b0; illegal_q <= 1'b0;
    end else if (!stall) begin
      in_valid_q  <= 1'b1;
      pc_dly_q    <= pc_in;
      valid_q     <= in_valid_q;
      pc_out_q    <= pc_dly_q;
      rs1_q       <= instr_in[15 +: REG_ADDR_WIDTH];
      rs2_q       <= instr_in[20 +: REG_ADDR_WIDTH];
      rd_q        <= instr_in[7 +: REG_ADDR_WIDTH];
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      funct3_q    <= funct3;
      src_b_imm_q <= src_b_imm_d;
      reg_we_q    <= reg_we_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      illegal_q   <= illegal_d;
    end
  end

  assign valid_out     = valid_q;
  assign pc_out        = pc_out_q;
  assign rs1_addr      = rs1_q;
  assign rs2_addr      = rs2_q;
  assign rd_addr       = rd_q;
  assign imm           = imm_q;
  assign alu_op        = alu_op_q;
  assign src_b_imm     = src_b_imm_q;
  assign reg_we        = reg_we_q;
  assign mem_re        = mem_re_q;
  assign mem_we        = mem_we_q;
  assign mem_funct3    = funct3_q;
  assign branch_op     = branch_q;
  assign jump_op       = jump_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for the decode stage.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] instr_in;
  logic [11:0] pc_in;
  logic        valid_out;
  logic [11:0] pc_out;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        src_b_imm, reg_we, mem_re, mem_we, branch_op, jump_op, illegal_instr;
  logic [2:0]  mem_funct3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .instr_in(instr_in), .pc_in(pc_in),
    .valid_out(valid_out), .pc_out(pc_out),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .alu_op(alu_op), .src_b_imm(src_b_imm), .reg_we(reg_we),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .branch_op(branch_op), .jump_op(jump_op), .illegal_instr(illegal_instr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [11:0] pc, input logic [31:0] ins);
    pc_in = pc;
    instr_in = ins;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enables();
    return {26'b0, reg_we, mem_re, mem_we, branch_op, jump_op, illegal_instr};
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_in = '0; instr_in = '0;
    @(negedge clk);
    repeat (3) step(12'd0, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_pc", {20'b0, pc_out}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_en", enables(), 32'd0);

    rst = 1'b0;
    step(12'd0, 32'h0);
    chk("first_edge_valid", {31'b0, valid_out}, 32'd0);
    step(12'd1, 32'h00500093);                  // addi x1,x0,5
    chk("addi_valid", {31'b0, valid_out}, 32'd1);
    chk("addi_pc", {20'b0, pc_out}, 32'd0);
    chk("addi_regs", {17'b0, rd_addr, rs1_addr, 5'd0}, {17'b0, 5'd1, 5'd0, 5'd0});
    chk("addi_imm", imm, 32'd5);
    chk("addi_ctl", {26'b0, alu_op, src_b_imm, reg_we}, {26'b0, 4'b0000, 1'b1, 1'b1});

    step(12'd2, 32'h00000013);                  // addi x0,x0,0
    chk("nop_valid", {31'b0, valid_out}, 32'd1);
    chk("nop_en", enables(), 32'd0);
    step(12'd3, 32'h00000000);
    chk("zero_en", enables(), 32'b000001);
    step(12'd4, 32'h402081B3);                  // sub x3,x1,x2
    chk("sub_ctl", {26'b0, alu_op, reg_we, illegal_instr}, {26'b0, 4'b1000, 1'b1, 1'b0});
    chk("sub_imm", imm, 32'd0);
    step(12'd5, 32'hFE20AE23);                  // sw x2,-4(x1)
    chk("sw_pc", {20'b0, pc_out}, 32'd4);
    chk("sw_regs", {22'b0, rs1_addr, rs2_addr}, {22'b0, 5'd1, 5'd2});
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_ctl", {28'b0, mem_funct3, mem_we}, {28'b0, 3'b010, 1'b1});
    chk("sw_en", enables(), 32'b001000);
    step(12'd6, 32'hFE208CE3);                  // beq x1,x2,-8
    chk("beq_imm", imm, 32'hFFFFFFF8);
    chk("beq_en", enables(), 32'b000100);
    step(12'd7, 32'h010000EF);                  // jal x1,16
    chk("jal_imm", imm, 32'd16);
    chk("jal_en", enables(), 32'b100010);

    flush = 1'b1;
    step(12'd8, 32'h123452B7);                  // lui in flight, squashed
    flush = 1'b0;
    chk("flush_b1_valid", {31'b0, valid_out}, 32'd0);
    chk("flush_b1_en", enables(), 32'd0);
    step(12'd8, 32'h402081B3);                  // stale word from pre-override PC
    chk("flush_b2_valid", {31'b0, valid_out}, 32'd0);
    chk("flush_b2_en", enables(), 32'd0);
    step(12'd9, 32'h4030D093);                  // srai x1,x1,3 at pc 8
    chk("srai_valid", {31'b0, valid_out}, 32'd1);
    chk("srai_pc", {20'b0, pc_out}, 32'd8);
    chk("srai_ctl", {26'b0, alu_op, reg_we, illegal_instr}, {26'b0, 4'b1101, 1'b1, 1'b0});
    chk("srai_imm", imm, 32'h00000403);
    step(12'd10, 32'h0020A063);                 // branch funct3=010: illegal
    chk("badbr_pc", {20'b0, pc_out}, 32'd9);
    chk("badbr_en", enables(), 32'b000001);

    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(12'd11, 32'h123452B7);
      chk("stall_valid", {31'b0, valid_out}, 32'd1);
      chk("stall_pc", {20'b0, pc_out}, 32'd9);
      chk("stall_en", enables(), 32'b000001);
    end
    stall = 1'b0;
    step(12'd11, 32'h123452B7);                 // lui x5,0x12345 at pc 10
    chk("resume_pc", {20'b0, pc_out}, 32'd10);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_ctl", {26'b0, alu_op, src_b_imm, reg_we}, {26'b0, 4'b0000, 1'b1, 1'b1});
    step(12'd12, 32'h00000013);
    chk("resume_next_pc", {20'b0, pc_out}, 32'd11);

    flush = 1'b1; stall = 1'b1;
    step(12'd13, 32'h00500093);
    flush = 1'b0; stall = 1'b0;
    chk("flush_stall_valid", {31'b0, valid_out}, 32'd0);
    step(12'd20, 32'h0);
    chk("fs_bubble_valid", {31'b0, valid_out}, 32'd0);
    step(12'd21, 32'h00500093);
    chk("fs_resume_valid", {31'b0, valid_out}, 32'd1);
    chk("fs_resume_pc", {20'b0, pc_out}, 32'd20);

    stall = 1'b1; rst = 1'b1;
    step(12'd22, 32'h00500093);
    chk("rst_stall_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_stall_pc", {20'b0, pc_out}, 32'd0);
    chk("rst_stall_imm", imm, 32'd0);
    chk("rst_stall_en", enables(), 32'd0);
    chk("rst_stall_rd", {27'b0, rd_addr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
